flash_sample_reader: RTL
========================

Name: flash_sample_reader

Overview:
- Responder side of the updater's read/addr request interface.
- On each read strobe, fetches one 32-bit word from flash over an Avalon-MM-style read port.
- Splits the word into two 16-bit PCM samples and presents them one per sample_en tick, in playback-direction order.
- Reports completion back to the updater so it can advance addr.

Parameters:
ADDR_W, 23, flash word-address width
DATA_W, 32, flash data width; must be 2*SAMPLE_W
SAMPLE_W, 16, audio sample width
TIMEOUT_CYC, 1024, watchdog limit in clk cycles (only with READ_TIMEOUT_EN)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-low reset (0 = reset)
read  in  1  request strobe from updater; sampled while IDLE only
addr  in  ADDR_W  flash word address; valid with read
reverse  in  1  1 = rewind playback (upper half first), 0 = forward (lower half first)
sample_en  in  1  single-cycle sample-rate enable (22 kHz) in clk domain
flash_mem_read  out  1  Avalon read request
flash_mem_address  out  ADDR_W  Avalon address
flash_mem_waitrequest  in  1  Avalon stall
flash_mem_readdatavalid  in  1  Avalon data valid
flash_mem_readdata  in  DATA_W  Avalon read data
audio_out  out  SAMPLE_W  current sample to codec
sample_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after second sample emitted
overrun  out  1  sticky; set when read=1 while busy; cleared only by reset

Behaviour:
- Reset (reset=0 at rising clk): state=IDLE; all outputs 0, including audio_out and overrun.
- IDLE:
  - read=1 → latch addr and reverse into internal registers → REQ.
  - busy rises on the next cycle.
- REQ:
  - flash_mem_read=1; flash_mem_address=latched addr.
  - Hold while waitrequest=1.
  - First cycle with waitrequest=0 → WAIT_DATA; flash_mem_read drops in that cycle.
  - Minimum latency read→WAIT_DATA is 2 clks.
- WAIT_DATA:
  - On readdatavalid=1, capture readdata into word register → EMIT0.
  - readdatavalid while not in WAIT_DATA is ignored.
- EMIT0:
  - Wait for sample_en=1.
  - That cycle: audio_out ← word[15:0] (reverse=0) or word[31:16] (reverse=1); sample_valid=1 → EMIT1.
- EMIT1:
  - Next sample_en: audio_out ← other half; sample_valid=1 → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- read is accepted in IDLE only:
  - read=1 in any other state is dropped and sets overrun.
  - read=1 and done in the same cycle counts as an overrun, because the FSM is still in DONE.
- audio_out holds its value between updates; it is never cleared except by reset.
- sample_en arriving in REQ or WAIT_DATA is ignored; no sample is emitted or queued.
- reverse is sampled only at request acceptance; changes mid-transaction have no effect.
- Addresses are passed through unchanged; there is no wrap logic here (wrap is owned by the updater).
- Reset mid-transaction returns to IDLE on the same edge.
  - flash_mem_read deasserts immediately.
  - A late readdatavalid after reset is ignored.

Optional Feature:
- Macro: READ_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and WAIT_DATA and clears on state entry.
  - Reaching TIMEOUT_CYC → abort to DONE; done pulses; audio_out is unchanged; sample_valid is not asserted.
  - Extra output port timeout (1 bit), sticky until reset.
- Undefined: no counter and no timeout port; the FSM waits indefinitely on waitrequest/readdatavalid.

Test Plan:
- Forward read:
  - Stimulus: read=1, addr=0x000010, reverse=0, waitrequest low, readdatavalid 3 clks later with data 0xBEEF1234, two sample_en pulses.
  - Response: flash_mem_address=0x000010; audio_out=0x1234 then 0xBEEF; two sample_valid pulses; done one cycle after the second sample.
- Reverse read: same data with reverse=1 → audio_out=0xBEEF then 0x1234.
- Stall:
  - Stimulus: waitrequest held 5 clks.
  - Response: flash_mem_read and address stable all 5 clks; exactly one read issued.
- Overrun:
  - Stimulus: read pulsed in WAIT_DATA with addr=0x000020.
  - Response: overrun=1; flash_mem_address never becomes 0x000020; the first transaction completes normally.
- Reset mid-read:
  - Stimulus: reset=0 during WAIT_DATA, then readdatavalid with data 0xFFFFFFFF after release.
  - Response: busy=0, audio_out=0, no sample_valid.
- READ_TIMEOUT_EN, TIMEOUT_CYC=16, readdatavalid never asserted → done pulses 16 clks after entering WAIT_DATA; timeout=1.

Source files
------------

// File: rtl/flash_sample_reader.sv
// ---------------------------------------------------------------------------
// flash_sample_reader
//
// Purpose:
//   Responder side of the playback updater's read/addr request interface.
//   Each accepted read strobe fetches one DATA_W-bit word from flash over an
//   Avalon-MM style read port. The word is split into two SAMPLE_W-bit PCM
//   samples, and they are presented to the codec one per sample_en tick in
//   playback-direction order. When the second sample has gone out, done
//   pulses so the updater can advance its address.
//
// Optional feature (compile-time macro READ_TIMEOUT_EN):
//   When defined, a watchdog counts clk cycles spent in REQ and WAIT_DATA.
//   Reaching TIMEOUT_CYC aborts the transaction straight to DONE. audio_out
//   is left untouched, no sample_valid is produced and the sticky timeout
//   output is set. When undefined, the FSM waits on the bus indefinitely and
//   the timeout port does not exist.
//
// Handshakes:
//   Updater side : read is a strobe. It is taken only in IDLE, together with
//                  addr and reverse. A strobe in any other state is dropped
//                  and raises the sticky overrun flag. done is the one-cycle
//                  completion pulse for the accepted request.
//   Flash side   : flash_mem_read is held with a stable flash_mem_address.
//                  A cycle with flash_mem_read=1 and waitrequest=0 transfers
//                  the command. The data returns later, in the single cycle
//                  that has readdatavalid=1. readdatavalid outside WAIT_DATA
//                  is ignored.
//   Codec side   : sample_valid pulses for one cycle, in the first cycle
//                  that shows the new audio_out value.
//
// Ports:
//   clk                     in   system clock
//   reset                   in   synchronous reset, active low
//   read                    in   request strobe from updater
//   addr       [ADDR_W]     in   flash word address, valid with read
//   reverse                 in   1 = upper half first, 0 = lower half first
//   sample_en               in   single-cycle sample-rate enable
//   flash_mem_read          out  Avalon read request
//   flash_mem_address       out  Avalon address (latched request address)
//   flash_mem_waitrequest   in   Avalon stall
//   flash_mem_readdatavalid in   Avalon read data valid
//   flash_mem_readdata      in   Avalon read data
//   audio_out  [SAMPLE_W]   out  current sample to codec (held between updates)
//   sample_valid            out  one-cycle pulse when audio_out updates
//   busy                    out  high in every state except IDLE
//   done                    out  one-cycle completion pulse (DONE state)
//   overrun                 out  sticky: read seen while not IDLE
//   timeout                 out  sticky watchdog flag (READ_TIMEOUT_EN only)
//   state_dbg  [3]          out  current FSM state encoding
// ---------------------------------------------------------------------------
module flash_sample_reader #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int SAMPLE_W    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                reverse,
    input  logic                sample_en,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    input  logic                flash_mem_waitrequest,
    input  logic                flash_mem_readdatavalid,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    output logic [SAMPLE_W-1:0] audio_out,
    output logic                sample_valid,
    output logic                busy,
    output logic                done,
    output logic                overrun,
`ifdef READ_TIMEOUT_EN
    output logic                timeout,
`endif
    output logic [2:0]          state_dbg
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter sanity.
    // -----------------------------------------------------------------------
    if (DATA_W != 2 * SAMPLE_W) begin : g_bad_width
        $error("flash_sample_reader: DATA_W must equal 2*SAMPLE_W");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("flash_sample_reader: TIMEOUT_CYC must be at least 2");
    end

    // -----------------------------------------------------------------------
    // State encoding (also exported on state_dbg).
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_EMIT0     = 3'd3,
        S_EMIT1     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request context captured at acceptance. It stays stable for the whole
    // transaction, so later changes to addr or reverse have no effect.
    logic [ADDR_W-1:0]   addr_q;
    logic                rev_q;
    logic [DATA_W-1:0]   word_q;
    logic [SAMPLE_W-1:0] audio_q;
    logic                sample_valid_q;
    logic                overrun_q;

    // The two halves of the fetched word.
    logic [SAMPLE_W-1:0] word_lo;
    logic [SAMPLE_W-1:0] word_hi;

    assign word_lo = word_q[SAMPLE_W-1:0];
    assign word_hi = word_q[DATA_W-1:SAMPLE_W];

    // Watchdog abort request. This is always 0 when the feature is compiled
    // out.
    logic timeout_hit;

`ifdef READ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] timer_q;
    logic             timeout_q;
    logic             in_bus_wait;

    assign in_bus_wait = (state_q == S_REQ) || (state_q == S_WAIT_DATA);

    // The timer counts cycles in the current state. A timer value of
    // TIMEOUT_CYC-1 means the state has been occupied for TIMEOUT_CYC
    // cycles, so the abort lands exactly TIMEOUT_CYC clocks after entry.
    assign timeout_hit = in_bus_wait && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (in_bus_wait) begin
                timer_q <= timer_q + 1'b1;
            end
            if (in_bus_wait && (state_d == S_DONE)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Process 1: state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state logic.
    // Normal bus progress takes priority over the watchdog. If the command
    // is accepted, or the data arrives, in the same cycle the limit is
    // reached, the transaction completes normally.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (read) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!flash_mem_waitrequest) begin
                    state_d = S_WAIT_DATA;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_DATA: begin
                if (flash_mem_readdatavalid) begin
                    state_d = S_EMIT0;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_EMIT0: begin
                if (sample_en) begin
                    state_d = S_EMIT1;
                end
            end
            S_EMIT1: begin
                if (sample_en) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Process 3: state-decoded outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        flash_mem_read = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        unique case (state_q)
            S_IDLE:  busy           = 1'b0;
            S_REQ:   flash_mem_read = 1'b1;
            S_DONE:  done           = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state_q;

    // -----------------------------------------------------------------------
    // Datapath registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q         <= '0;
            rev_q          <= 1'b0;
            word_q         <= '0;
            audio_q        <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;

            // Capture the request context at acceptance.
            if ((state_q == S_IDLE) && read) begin
                addr_q <= addr;
                rev_q  <= reverse;
            end

            // A strobe outside IDLE is dropped. This includes the DONE cycle,
            // because the FSM has not yet returned to IDLE.
            if ((state_q != S_IDLE) && read) begin
                overrun_q <= 1'b1;
            end

            // Accept read data only while it is actually awaited.
            if ((state_q == S_WAIT_DATA) && flash_mem_readdatavalid) begin
                word_q <= flash_mem_readdata;
            end

            // First sample: lower half going forward, upper half in rewind.
            if ((state_q == S_EMIT0) && sample_en) begin
                audio_q        <= rev_q ? word_hi : word_lo;
                sample_valid_q <= 1'b1;
            end

            // Second sample: the other half.
            if ((state_q == S_EMIT1) && sample_en) begin
                audio_q        <= rev_q ? word_lo : word_hi;
                sample_valid_q <= 1'b1;
            end
        end
    end

    assign flash_mem_address = addr_q;
    assign audio_out         = audio_q;
    assign sample_valid      = sample_valid_q;
    assign overrun           = overrun_q;

endmodule
